key_sel_counter: RTL and testbench
==================================

// Module: key_sel_counter
// PURPOSE
//  Front-end stage feeding the 3-to-8 LED decoder: turns two raw, bouncing,
//  active-low push keys (UP, DOWN) into a stable 3-bit select code.
//  Per key: 2-flop synchronizer, then a stability-counter debouncer, then
//  press-edge detection. The select code is a wrap-around up/down counter.
//  Output sel connects directly to the decoder's 3-bit sw input.
// PARAMETERS
//  DEB_CYCLES  240000  consecutive stable cycles to accept a key change (20 ms @ 12 MHz); >=2
//  CNT_W       18      debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES
//  INIT_SEL    3'd0    sel value loaded at reset
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous reset, active low
//  key_up_n  in   1  raw UP key, active low (0 = pressed), asynchronous to clk
//  key_dn_n  in   1  raw DOWN key, active low, asynchronous to clk
//  sel       out  3  registered select code to decoder
//  sel_chg   out  1  one-cycle pulse, high in the cycle sel holds a new value
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): sync flops=1, debounced state=1 (released),
//   debounce counters=0, sel=INIT_SEL, sel_chg=0. Reset mid-debounce discards
//   all pending progress; no event is produced.
//  Per key, identical logic:
//   s1<=raw; s2<=s1 (2-flop synchronizer).
//   If s2==deb: cnt<=0.
//   If s2!=deb and cnt==DEB_CYCLES-1: deb<=s2, cnt<=0.
//   Otherwise: cnt<=cnt+1.
//   Any sample with s2==deb restarts the count; a bounce shorter than
//   DEB_CYCLES never changes deb.
//   Press event = deb transitions 1->0 on this edge. Release (0->1) produces
//   no event.
//  Counter update, on the same edge that deb flips:
//   UP event only:   sel<=sel+1 mod 8 (7->0 wraps), sel_chg<=1.
//   DOWN event only: sel<=sel-1 mod 8 (0->7 wraps), sel_chg<=1.
//   Both events on the same edge: sel unchanged, sel_chg<=0.
//   No event: sel holds, sel_chg<=0.
//  Latency: a key held steadily low is first sampled by s1 on edge 1.
//   sel/sel_chg update on edge DEB_CYCLES+2.
//  Holding a key: exactly one event per press; no auto-repeat.
//  A key held low through reset release counts as a press after full
//   debounce, because deb restarts at 1.
//  sel_chg is never high for two consecutive cycles. It is not asserted
//   by reset.
// TESTING (bench overrides DEB_CYCLES=4, CNT_W=3)
//  1 Reset: rst_n=0 with keys=1 -> sel=0, sel_chg=0; release rst_n, 20 idle
//    cycles -> sel stays 0, sel_chg never 1.
//  2 Clean UP press: key_up_n low from edge 1, held 20 cycles -> sel=1 and
//    sel_chg=1 on edge 6 only; release -> no further change.
//  3 Bounce: key_up_n toggles 0/1 every 2 cycles for 30 cycles, then settles
//    low -> exactly one increment, occurring 6 edges after the final settle.
//  4 Wrap: 8 UP presses from 0 -> sel 1..7,0 with 8 sel_chg pulses; then
//    1 DOWN press -> sel=7.
//  5 Simultaneous: both keys low on the same edge, held 20 cycles -> sel
//    unchanged, sel_chg stays 0.
//  6 Reset mid-debounce: UP low 3 cycles, then rst_n pulsed low with key still
//    held -> sel=0 during reset; after release sel=1 exactly 6 edges later.

Source files
------------

// File: rtl/key_sel_counter.sv
// Debounced up/down key front end for the 3-to-8 LED decoder: two raw active-low
// keys are synchronized, debounced and edge-detected into a wrapping 3-bit select.
module key_sel_counter #(
  parameter int         DEB_CYCLES = 240000,
  parameter int         CNT_W      = 18,
  parameter logic [2:0] INIT_SEL   = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic [2:0] sel,
  output logic       sel_chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Index 0 is the UP key, index 1 is the DOWN key.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       deb;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];

  assign raw = {key_dn_n, key_up_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 2'b11;
      s2  <= 2'b11;
      deb <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the debounced level falling 1->0 on this very edge.
  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      press[i] = deb[i] & ~s2[i] & (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= INIT_SEL;
      sel_chg <= 1'b0;
    end else begin
      case (press)
        2'b01: begin
          sel     <= sel + 3'd1;
          sel_chg <= 1'b1;
        end
        2'b10: begin
          sel     <= sel - 3'd1;
          sel_chg <= 1'b1;
        end
        default: begin
          sel_chg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sel_counter.sv
// Bench for key_sel_counter with a short debounce window; select changes are
// checked against an expected queue, timing against fixed edge counts.
module tb_key_sel_counter;

  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  logic       clk;
  logic       rst_n;
  logic       key_up_n;
  logic       key_dn_n;
  logic [2:0] sel;
  logic       sel_chg;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  key_sel_counter #(.DEB_CYCLES(DEB), .CNT_W(3), .INIT_SEL(3'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .sel      (sel),
    .sel_chg  (sel_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every sel_chg pulse pops one expected select value.
  logic prev_chg = 1'b0;
  initial begin
    forever begin
      tick();
      if (rst_n && sel_chg) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sel_chg", 1, 0);
        end else begin
          check("sb_sel", int'(sel), int'(exp_q.pop_front()));
        end
        check("sel_chg_back_to_back", int'(prev_chg), 0);
      end
      prev_chg = sel_chg;
    end
  end

  task automatic hold_keys(input logic up, input logic dn, input int hold,
                           input logic [2:0] exp_sel, input logic exp_chg,
                           input string name);
    int pulses;
    int first;
    pulses = 0;
    first  = 0;
    if (exp_chg) exp_q.push_back(exp_sel);
    key_up_n = ~up;
    key_dn_n = ~dn;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (sel_chg) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check({name, "_pulses"}, pulses, exp_chg ? 1 : 0);
    if (exp_chg) check({name, "_edge"}, first, LAT);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sel_chg) pulses++;
    end
    check({name, "_release_pulses"}, pulses, 0);
    check({name, "_sel"}, int'(sel), int'(exp_sel));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       up;
    logic       dn;
    logic [2:0] exp_sel;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int pulses;
    int first;

    vecs[0]  = '{1'b1, 1'b0, 3'd1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'd2, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'd4, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 3'd5, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'd6, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'd7, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 3'd7, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 3'd7, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'd6, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 3'd5, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 3'd6, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 3'd6, 1'b0};

    // Reset state and idle behaviour.
    rst_n    = 1'b0;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    #2;
    check("reset_sel", int'(sel), 0);
    check("reset_sel_chg", int'(sel_chg), 0);
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel_chg) pulses++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_sel", int'(sel), 0);

    // Clean UP press.
    hold_keys(1'b1, 1'b0, 20, 3'd1, 1'b1, "clean_up");

    // Bouncing UP key, then settle low.
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      key_up_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (sel_chg) pulses++;
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_sel", int'(sel), 1);
    hold_keys(1'b1, 1'b0, 20, 3'd2, 1'b1, "bounce_settle");

    // Wrap, down and simultaneous presses from a fresh reset.
    apply_reset();
    check("post_reset_sel", int'(sel), 0);
    for (int v = 0; v < 14; v++) begin
      hold_keys(vecs[v].up, vecs[v].dn, 20, vecs[v].exp_sel, vecs[v].exp_chg,
                $sformatf("vec%0d", v));
    end

    // Reset in the middle of a debounce with the key still held.
    key_up_n = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("middeb_reset_sel", int'(sel), 0);
    check("middeb_reset_chg", int'(sel_chg), 0);
    tick();
    tick();
    exp_q.push_back(3'd1);
    rst_n = 1'b1;
    first = 0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sel_chg) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("middeb_pulses", pulses, 1);
    check("middeb_edge", first, LAT);
    check("middeb_sel", int'(sel), 1);
    key_up_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
